// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0/E1 prefix sequences into {ext, brk, code}
// key events, queues them in a 4-deep FWFT FIFO and tracks held extended arrow keys.
module ps2_scancode_decoder #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_code_valid,
  input  logic [7:0] i_code,
  input  logic       i_code_err,
  input  logic       i_evt_rd,
  output logic       o_evt_empty,
  output logic [9:0] o_evt_data,
  output logic [3:0] o_arrows,
  output logic       o_bat_ok,
  output logic       o_kb_err,
  output logic       o_frame_err,
  output logic       o_overflow
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_tmo;
  logic [2:0]  r_skip;
  logic [9:0]  r_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic [3:0]  r_arrows;
  logic        r_bat_ok;
  logic        r_kb_err;
  logic        r_frame_err;
  logic        r_overflow;

  logic [2:0]  w_next_state;
  logic [2:0]  w_next_skip;
  logic        w_push;
  logic [9:0]  w_push_data;
  logic        w_bat;
  logic        w_kberr;
  logic        w_fake_shift;
  logic        w_pop;
  logic        w_full;
  logic        w_push_ok;

  assign w_fake_shift = (i_code == 8'h12) || (i_code == 8'h59);

  always_comb begin
    w_next_state = r_state;
    w_next_skip  = r_skip;
    w_push       = 1'b0;
    w_push_data  = {2'b00, i_code};
    w_bat        = 1'b0;
    w_kberr      = 1'b0;
    if (i_code_valid && i_code_err) begin
      w_next_state = S_IDLE;
    end else if (i_code_valid) begin
      case (r_state)
        S_IDLE: begin
          if (i_code == 8'hE0)      w_next_state = S_EXT;
          else if (i_code == 8'hF0) w_next_state = S_BRK;
          else if (i_code == 8'hE1) begin
            w_next_state = S_PAUSE;
            w_next_skip  = 3'd7;
          end
          else if (i_code == 8'hAA) w_bat   = 1'b1;
          else if (i_code == 8'hFC) w_kberr = 1'b1;
          else                      w_push  = 1'b1;
        end
        S_EXT: begin
          if (i_code == 8'hF0)      w_next_state = S_EXT_BRK;
          else if (i_code == 8'hE0) w_next_state = S_EXT;
          else if (w_fake_shift)    w_next_state = S_IDLE;
          else begin
            w_push       = 1'b1;
            w_push_data  = {2'b10, i_code};
            w_next_state = S_IDLE;
          end
        end
        S_BRK: begin
          if (i_code == 8'hF0)      w_next_state = S_BRK;
          else if (i_code == 8'hE0) w_next_state = S_EXT_BRK;
          else begin
            w_push       = 1'b1;
            w_push_data  = {2'b01, i_code};
            w_next_state = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (w_fake_shift) w_next_state = S_IDLE;
          else if ((i_code == 8'hE0) || (i_code == 8'hF0)) w_next_state = S_EXT_BRK;
          else begin
            w_push       = 1'b1;
            w_push_data  = {2'b11, i_code};
            w_next_state = S_IDLE;
          end
        end
        S_PAUSE: begin
          // The 7 bytes after E1 carry no information; the whole sequence is one key.
          w_next_skip = r_skip - 3'd1;
          if (r_skip <= 3'd1) begin
            w_next_skip  = 3'd0;
            w_push       = 1'b1;
            w_push_data  = {2'b10, 8'h77};
            w_next_state = S_IDLE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end else if ((r_state != S_IDLE) && (r_tmo == TIMEOUT - 16'd1)) begin
      w_next_state = S_IDLE;
    end
  end

  assign w_pop     = i_evt_rd && (r_count != 3'd0);
  assign w_full    = (r_count == 3'd4);
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_tmo       <= 16'd0;
      r_skip      <= 3'd0;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_count     <= 3'd0;
      r_arrows    <= 4'd0;
      r_bat_ok    <= 1'b0;
      r_kb_err    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_skip      <= w_next_skip;
      r_tmo       <= (i_code_valid || (w_next_state == S_IDLE)) ? 16'd0 : r_tmo + 16'd1;
      r_bat_ok    <= w_bat;
      r_kb_err    <= w_kberr;
      r_frame_err <= i_code_valid && i_code_err;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 2'd1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 3'd1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 3'd1;
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
      // Arrow state follows the key even when its event could not be queued.
      if (w_push && w_push_data[9]) begin
        case (w_push_data[7:0])
          8'h75:   r_arrows[3] <= !w_push_data[8];
          8'h72:   r_arrows[2] <= !w_push_data[8];
          8'h6B:   r_arrows[1] <= !w_push_data[8];
          8'h74:   r_arrows[0] <= !w_push_data[8];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign o_evt_empty = (r_count == 3'd0);
  assign o_evt_data  = o_evt_empty ? 10'h000 : r_mem[r_rd_ptr];
  assign o_arrows    = r_arrows;
  assign o_bat_ok    = r_bat_ok;
  assign o_kb_err    = r_kb_err;
  assign o_frame_err = r_frame_err;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder; inputs change and outputs
// are sampled on the falling clock edge.
module tb_ps2_scancode_decoder;

  localparam int TIMEOUT_CYCLES = 50000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       code_err = 1'b0;
  logic       evt_rd = 1'b0;
  logic       evt_empty;
  logic [9:0] evt_data;
  logic [3:0] arrows;
  logic       bat_ok;
  logic       kb_err;
  logic       frame_err;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.TIMEOUT(16'd50000)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_code_valid (code_valid),
    .i_code       (code),
    .i_code_err   (code_err),
    .i_evt_rd     (evt_rd),
    .o_evt_empty  (evt_empty),
    .o_evt_data   (evt_data),
    .o_arrows     (arrows),
    .o_bat_ok     (bat_ok),
    .o_kb_err     (kb_err),
    .o_frame_err  (frame_err),
    .o_overflow   (overflow)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One code byte strobed for a single cycle; returns on the falling edge after it was taken.
  task automatic applyStimulus(input logic [7:0] c, input logic e);
    @(negedge clk);
    code_valid = 1'b1;
    code       = c;
    code_err   = e;
    @(negedge clk);
    code_valid = 1'b0;
    code_err   = 1'b0;
  endtask

  task automatic popEvent();
    @(negedge clk);
    evt_rd = 1'b1;
    @(negedge clk);
    evt_rd = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_empty"}, 16'(evt_empty), 16'h1);
    checkOutput({tag, "_data"}, 16'(evt_data), 16'h000);
    checkOutput({tag, "_arrows"}, 16'(arrows), 16'h0);
    checkOutput({tag, "_pulses"}, 16'({bat_ok, kb_err, frame_err}), 16'h0);
    checkOutput({tag, "_ovf"}, 16'(overflow), 16'h0);
  endtask

  initial begin
    doReset();
    checkResetState("reset");

    // Make / break of a plain key
    applyStimulus(8'h1C, 1'b0);
    checkOutput("make_head", 16'(evt_data), 16'h01C);
    checkOutput("make_empty", 16'(evt_empty), 16'h0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h1C, 1'b0);
    checkOutput("brk_head_kept", 16'(evt_data), 16'h01C);
    popEvent();
    checkOutput("brk_head", 16'(evt_data), 16'h11C);
    popEvent();
    checkOutput("mb_empty", 16'(evt_empty), 16'h1);
    checkOutput("mb_arrows", 16'(arrows), 16'h0);

    // Extended arrow versus keypad key
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    checkOutput("up_make_arrows", 16'(arrows), 16'h8);
    applyStimulus(8'h75, 1'b0);
    checkOutput("keypad_arrows", 16'(arrows), 16'h8);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    checkOutput("up_brk_arrows", 16'(arrows), 16'h0);
    checkOutput("arrow_ev0", 16'(evt_data), 16'h275);
    popEvent();
    checkOutput("arrow_ev1", 16'(evt_data), 16'h075);
    popEvent();
    checkOutput("arrow_ev2", 16'(evt_data), 16'h375);
    popEvent();
    checkOutput("arrow_empty", 16'(evt_empty), 16'h1);

    // Frame error mid-prefix
    applyStimulus(8'hE0, 1'b1);
    checkOutput("ferr_pulse", 16'(frame_err), 16'h1);
    checkOutput("ferr_noevt", 16'(evt_empty), 16'h1);
    @(negedge clk);
    checkOutput("ferr_pulse_end", 16'(frame_err), 16'h0);
    applyStimulus(8'h1C, 1'b0);
    checkOutput("ferr_recover", 16'(evt_data), 16'h01C);
    popEvent();

    // Prefix timeout
    applyStimulus(8'hE0, 1'b0);
    for (int i = 0; i < TIMEOUT_CYCLES; i++) @(negedge clk);
    applyStimulus(8'h1C, 1'b0);
    checkOutput("tmo_recover", 16'(evt_data), 16'h01C);
    popEvent();
    checkOutput("tmo_empty", 16'(evt_empty), 16'h1);

    // Pause sequence yields exactly one event
    applyStimulus(8'hE1, 1'b0);
    applyStimulus(8'h14, 1'b0);
    applyStimulus(8'h77, 1'b0);
    applyStimulus(8'hE1, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h14, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    checkOutput("pause_pending", 16'(evt_empty), 16'h1);
    applyStimulus(8'h77, 1'b0);
    checkOutput("pause_evt", 16'(evt_data), 16'h277);
    popEvent();
    checkOutput("pause_single", 16'(evt_empty), 16'h1);

    // Fake shift is swallowed
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h7C, 1'b0);
    checkOutput("fake_evt", 16'(evt_data), 16'h27C);
    popEvent();
    checkOutput("fake_single", 16'(evt_empty), 16'h1);

    // FIFO overflow
    applyStimulus(8'h15, 1'b0);
    applyStimulus(8'h1D, 1'b0);
    applyStimulus(8'h24, 1'b0);
    applyStimulus(8'h2D, 1'b0);
    checkOutput("full_no_ovf", 16'(overflow), 16'h0);
    applyStimulus(8'h2C, 1'b0);
    checkOutput("ovf_set", 16'(overflow), 16'h1);
    checkOutput("ovf_pop0", 16'(evt_data), 16'h015);
    popEvent();
    checkOutput("ovf_pop1", 16'(evt_data), 16'h01D);
    popEvent();
    checkOutput("ovf_pop2", 16'(evt_data), 16'h024);
    popEvent();
    checkOutput("ovf_pop3", 16'(evt_data), 16'h02D);
    popEvent();
    checkOutput("ovf_drained", 16'(evt_empty), 16'h1);
    checkOutput("ovf_sticky", 16'(overflow), 16'h1);
    popEvent();
    checkOutput("pop_when_empty", 16'(evt_empty), 16'h1);

    // Push and pop together while full
    doReset();
    checkOutput("ovf_cleared", 16'(overflow), 16'h0);
    applyStimulus(8'h15, 1'b0);
    applyStimulus(8'h1D, 1'b0);
    applyStimulus(8'h24, 1'b0);
    applyStimulus(8'h2D, 1'b0);
    @(negedge clk);
    code_valid = 1'b1;
    code       = 8'h2C;
    evt_rd     = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    evt_rd     = 1'b0;
    checkOutput("pp_no_ovf", 16'(overflow), 16'h0);
    checkOutput("pp_head0", 16'(evt_data), 16'h01D);
    popEvent();
    checkOutput("pp_head1", 16'(evt_data), 16'h024);
    popEvent();
    checkOutput("pp_head2", 16'(evt_data), 16'h02D);
    popEvent();
    checkOutput("pp_head3", 16'(evt_data), 16'h02C);
    popEvent();
    checkOutput("pp_empty", 16'(evt_empty), 16'h1);

    // Self-test and error codes
    applyStimulus(8'hAA, 1'b0);
    checkOutput("bat_pulse", 16'(bat_ok), 16'h1);
    checkOutput("bat_noevt", 16'(evt_empty), 16'h1);
    @(negedge clk);
    checkOutput("bat_pulse_end", 16'(bat_ok), 16'h0);
    applyStimulus(8'hFC, 1'b0);
    checkOutput("kberr_pulse", 16'(kb_err), 16'h1);
    checkOutput("kberr_noevt", 16'(evt_empty), 16'h1);
    @(negedge clk);
    checkOutput("kberr_pulse_end", 16'(kb_err), 16'h0);

    // Reset mid-sequence with an arrow held
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h74, 1'b0);
    checkOutput("right_make", 16'(arrows), 16'h1);
    applyStimulus(8'hE0, 1'b0);
    doReset();
    checkResetState("midrst");
    applyStimulus(8'h75, 1'b0);
    checkOutput("midrst_evt", 16'(evt_data), 16'h075);
    checkOutput("midrst_arrows", 16'(arrows), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes raw 8-bit Set-2 scan codes from the PS/2 frame receiver and turns prefix sequences (E0 extended, F0 break, E1 pause) into single key events of {extended, break, code}. It sits directly downstream of the keyboard receiver and upstream of display and LED logic. It buffers events in a 4-entry FIFO, flags keyboard self-test and error codes, and keeps a held-state mask for the four extended arrow keys.

## Interface
- TIMEOUT, 16'd50000: CLK cycles a partial prefix sequence may wait for its next byte before being discarded.
- CLK  in  1  board clock; all logic on posedge.
- RST_N  in  1  reset; synchronous and active-low.
- CODE_VALID  in  1  one-cycle strobe: a frame was received.
- CODE  in  8  scan-code byte; valid with CODE_VALID.
- CODE_ERR  in  1  frame parity/start/stop error; valid with CODE_VALID.
- EVT_RD  in  1  pop the FIFO head. Ignored when EVT_EMPTY=1.
- EVT_EMPTY  out  1  FIFO empty.
- EVT_DATA  out  10  FIFO head {EXT, BRK, CODE[7:0]}. First-word-fall-through; 10'h000 when empty.
- ARROWS  out  4  held mask {UP, DOWN, LEFT, RIGHT}.
- BAT_OK  out  1  one-cycle pulse on code 8'hAA.
- KB_ERR  out  1  one-cycle pulse on code 8'hFC.
- FRAME_ERR  out  1  one-cycle pulse on CODE_VALID with CODE_ERR=1.
- OVERFLOW  out  1  sticky; set when an event is dropped because the FIFO is full. Cleared only by reset.

## Operation
- Reset (RST_N=0 at a CLK edge):
  - State IDLE; FIFO empty; timeout counter 0; pause skip counter 0.
  - Outputs: EVT_EMPTY=1, EVT_DATA=0, ARROWS=0, all pulses 0, OVERFLOW=0.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions below occur only on CODE_VALID with CODE_ERR=0.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE, loading the skip counter with 7.
    - AA -> pulse BAT_OK; no event.
    - FC -> pulse KB_ERR; no event.
    - Any other code -> push {0,0,code}.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay in EXT.
    - 12 or 59 (fake shift) -> drop; go to IDLE.
    - Any other code -> push {1,0,code}; go to IDLE.
  - BRK:
    - F0 -> stay in BRK.
    - E0 -> EXT_BRK.
    - Any other code -> push {0,1,code}; go to IDLE.
  - EXT_BRK:
    - 12 or 59 -> drop; go to IDLE.
    - E0 or F0 -> stay in EXT_BRK.
    - Any other code -> push {1,1,code}; go to IDLE.
  - PAUSE: every byte decrements the skip counter. When the counter reaches 0, push {1,0,8'h77} (pause key) and go to IDLE.
- Error handling:
  - CODE_VALID with CODE_ERR=1 in any state: pulse FRAME_ERR, go to IDLE, push nothing, leave ARROWS unchanged.
  - Timeout: in any non-IDLE state, the counter increments each cycle without CODE_VALID and clears on CODE_VALID. When it reaches TIMEOUT-1, go to IDLE with no event and no flag. The counter holds at 0 in IDLE.
- ARROWS:
  - Updated only on a pushed or attempted event with EXT=1.
  - Codes 75/72/6B/74 set bit UP/DOWN/LEFT/RIGHT when BRK=0 and clear it when BRK=1.
  - Non-extended 75/72/6B/74 (keypad keys) do not affect ARROWS.
  - ARROWS updates even if the FIFO push is dropped.
- FIFO:
  - Depth 4, 2-bit pointers that wrap modulo 4, and a 3-bit count (0..4).
  - Push when full: the event is dropped and OVERFLOW is set.
  - Push and pop in the same cycle: both take effect and the count is unchanged. When full, this push succeeds and OVERFLOW stays unset.
  - Pop when empty: no effect.

## Timing
- CODE_VALID sampled at edge n:
  - State, ARROWS and pulse outputs update at edge n; pulses are high for cycle n..n+1 only.
  - A pushed event is visible on EVT_DATA with EVT_EMPTY=0 from edge n. Push-to-head latency is 1 cycle.
- EVT_RD sampled at edge m: the next entry (or empty) is presented from edge m.
- Inputs are assumed synchronous to CLK. CODE_VALID pulses are at least 2 cycles apart.
- Reset mid-sequence (e.g. between E0 and F0) abandons the sequence; the next byte is decoded from IDLE.

## Test plan
- Make/break: 1C, then F0 1C -> FIFO holds 10'h01C, 10'h11C; ARROWS=0.
- Extended arrow: E0 75, then E0 F0 75 -> events 10'h275, 10'h375; ARROWS goes 4'b1000 after the make and back to 0 after the break. Keypad 75 alone -> event 10'h075 with ARROWS unchanged.
- Prefix recovery:
  - E0 with CODE_ERR=1, then 1C -> FRAME_ERR pulse, event 10'h01C.
  - E0, then TIMEOUT idle cycles, then 1C -> event 10'h01C.
- Pause and fake shift:
  - E1 14 77 E1 F0 14 F0 77 -> exactly one event, 10'h277.
  - E0 12 E0 7C -> single event 10'h27C.
- FIFO full:
  - Push 5 codes (15, 1D, 24, 2D, 2C) with no reads -> 4 entries kept, 2C dropped, OVERFLOW=1.
  - Pop all four -> 15, 1D, 24, 2D in order, then EVT_EMPTY=1.
  - With the FIFO full, push and EVT_RD in the same cycle -> count stays 4 and OVERFLOW stays 0.
- Special codes: AA -> BAT_OK one-cycle pulse, no event; FC -> KB_ERR pulse, no event.
- Reset: assert RST_N=0 after E0 -> all outputs return to reset values; the following 75 yields 10'h075.
